// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter in front of a shared 1-bit mux. One requester at a
//   time owns the mux select. A grant is held until the owner drops its
//   request, or for at most max_hold consecutive cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_in     per-requester request, level-sensitive
//   w_in       per-requester data bit (mux data inputs)
//   grant_out  registered one-hot grant, zero when idle
//   s_out      registered binary index of the current owner
//   valid_out  registered, high while a grant is active
//   f_out      w_in[s_out] while valid_out is high, else 0
module rr_mux_arbiter #(
    parameter int unsigned inputs   = 4,
    parameter int unsigned max_hold = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs-1:0]         req_in,
    input  logic [inputs-1:0]         w_in,
    output logic [inputs-1:0]         grant_out,
    output logic [$clog2(inputs)-1:0] s_out,
    output logic                      valid_out,
    output logic                      f_out
);

    localparam int unsigned SW = $clog2(inputs);
    localparam int unsigned HW = $clog2(max_hold + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [inputs-1:0] grant_q, grant_d;
    logic [SW-1:0]     s_q, s_d;
    logic              valid_q, valid_d;

    // First set bit of mask scanning start, start+1, ... wrapping at inputs
    // (not at a power of two).
    function automatic logic [SW-1:0] pick(input logic [inputs-1:0] mask,
                                           input logic [SW-1:0]     start);
        logic [SW-1:0] res;
        logic          found;
        int unsigned   idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < inputs; i++) begin
            idx = 32'(start) + i;
            if (idx >= inputs) idx = idx - inputs;
            if (!found && mask[idx[SW-1:0]]) begin
                found = 1'b1;
                res   = idx[SW-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [inputs-1:0] onehot(input logic [SW-1:0] idx);
        logic [inputs-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
        return (idx == SW'(inputs - 1)) ? '0 : idx + SW'(1);
    endfunction

    logic              own_req;
    logic              timeout;
    logic [SW-1:0]     ptr_rel;
    logic [inputs-1:0] other;
    logic [SW-1:0]     new_owner;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        s_d        = s_q;
        valid_d    = valid_q;

        own_req   = req_in[s_q];
        timeout   = (hold_cnt_q == HW'(max_hold));
        ptr_rel   = next_idx(s_q);
        other     = req_in & ~onehot(s_q);
        new_owner = '0;

        case (state_q)
            IDLE: begin
                if (req_in != '0) begin
                    new_owner  = pick(req_in, ptr_q);
                    grant_d    = onehot(new_owner);
                    s_d        = new_owner;
                    valid_d    = 1'b1;
                    hold_cnt_d = HW'(1);
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (own_req && !timeout) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end else begin
                    // Release: the pointer moves past the owner first, and any
                    // other requester is granted on this same edge from it.
                    ptr_d = ptr_rel;
                    if (other != '0) begin
                        new_owner  = pick(other, ptr_rel);
                        grant_d    = onehot(new_owner);
                        s_d        = new_owner;
                        hold_cnt_d = HW'(1);
                    end else if (own_req) begin
                        // Timed out as sole requester: re-grant without a gap.
                        hold_cnt_d = HW'(1);
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            s_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            s_q        <= s_d;
            valid_q    <= valid_d;
        end
    end

    assign grant_out = grant_q;
    assign s_out     = s_q;
    assign valid_out = valid_q;
    assign f_out     = valid_q & w_in[s_q];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Drives three arbiter instances (4 inputs / hold 8, 4 inputs / hold 2,
//   3 inputs / hold 3) from one clock and reset. A behavioural model predicts
//   each cycle's outputs; predictions are queued at drive time and compared
//   after the following clock edge.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req4, w4, grant4;
    logic [1:0] s4;
    logic       v4, f4;
    logic [3:0] reqh, wh, granth;
    logic [1:0] sh;
    logic       vh, fh;
    logic [2:0] req3, w3, grant3;
    logic [1:0] s3;
    logic       v3, f3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.inputs(4), .max_hold(8)) u_a4 (
        .clk(clk), .reset(reset), .req_in(req4), .w_in(w4),
        .grant_out(grant4), .s_out(s4), .valid_out(v4), .f_out(f4));

    rr_mux_arbiter #(.inputs(4), .max_hold(2)) u_h2 (
        .clk(clk), .reset(reset), .req_in(reqh), .w_in(wh),
        .grant_out(granth), .s_out(sh), .valid_out(vh), .f_out(fh));

    rr_mux_arbiter #(.inputs(3), .max_hold(3)) u_a3 (
        .clk(clk), .reset(reset), .req_in(req3), .w_in(w3),
        .grant_out(grant3), .s_out(s3), .valid_out(v3), .f_out(f3));

    typedef struct packed {
        logic [3:0] g4; logic [1:0] s4; logic v4; logic f4;
        logic [3:0] gh; logic [1:0] sh; logic vh; logic fh;
        logic [2:0] g3; logic [1:0] s3; logic v3; logic f3;
    } exp_t;

    typedef struct {
        int owner;
        int ptr;
        int hold;
        bit busy;
        int s;
    } mst_t;

    exp_t sb[$];
    mst_t m4, mh, m3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input bit [63:0] m, input int p, input int n);
        int j;
        for (int k = 0; k < n; k++) begin
            j = (p + k) % n;
            if (m[j]) return j;
        end
        return 0;
    endfunction

    function automatic mst_t step(input mst_t m, input bit [63:0] req, input bit rst,
                                  input int n, input int hmax);
        mst_t r;
        bit [63:0] oth;
        r = m;
        if (rst) begin
            r.busy = 0; r.ptr = 0; r.hold = 0; r.s = 0; r.owner = 0;
        end else if (!m.busy) begin
            if (req != 0) begin
                r.owner = scan(req, m.ptr, n);
                r.busy = 1; r.hold = 1; r.s = r.owner;
            end
        end else if (req[m.owner] && m.hold < hmax) begin
            r.hold = m.hold + 1;
        end else begin
            r.ptr = (m.owner + 1) % n;
            oth = req;
            oth[m.owner] = 1'b0;
            if (oth != 0) begin
                r.owner = scan(oth, r.ptr, n);
                r.s = r.owner; r.hold = 1;
            end else if (req[m.owner]) begin
                r.hold = 1;
            end else begin
                r.busy = 0;
            end
        end
        return r;
    endfunction

    task automatic cycle(input bit rst,
                         input logic [3:0] r4, input logic [3:0] wv4,
                         input logic [3:0] rh, input logic [3:0] wvh,
                         input logic [2:0] r3, input logic [2:0] wv3);
        exp_t e, o;
        reset = rst;
        req4 = r4; w4 = wv4; reqh = rh; wh = wvh; req3 = r3; w3 = wv3;
        m4 = step(m4, 64'(r4), rst, 4, 8);
        mh = step(mh, 64'(rh), rst, 4, 2);
        m3 = step(m3, 64'(r3), rst, 3, 3);
        e.g4 = m4.busy ? 4'(1 << m4.owner) : 4'b0;
        e.s4 = 2'(m4.s); e.v4 = m4.busy; e.f4 = m4.busy ? wv4[m4.owner] : 1'b0;
        e.gh = mh.busy ? 4'(1 << mh.owner) : 4'b0;
        e.sh = 2'(mh.s); e.vh = mh.busy; e.fh = mh.busy ? wvh[mh.owner] : 1'b0;
        e.g3 = m3.busy ? 3'(1 << m3.owner) : 3'b0;
        e.s3 = 2'(m3.s); e.v3 = m3.busy; e.f3 = m3.busy ? wv3[m3.owner] : 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("a4_grant", 64'(grant4), 64'(o.g4));
        check("a4_s",     64'(s4),     64'(o.s4));
        check("a4_valid", 64'(v4),     64'(o.v4));
        check("a4_f",     64'(f4),     64'(o.f4));
        check("h2_grant", 64'(granth), 64'(o.gh));
        check("h2_s",     64'(sh),     64'(o.sh));
        check("h2_valid", 64'(vh),     64'(o.vh));
        check("h2_f",     64'(fh),     64'(o.fh));
        check("a3_grant", 64'(grant3), 64'(o.g3));
        check("a3_s",     64'(s3),     64'(o.s3));
        check("a3_valid", 64'(v3),     64'(o.v3));
        check("a3_f",     64'(f3),     64'(o.f3));
        check("onehot_all", 64'({$onehot0(grant4), $onehot0(granth), $onehot0(grant3)}), 64'(3'b111));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m4 = '{0, 0, 0, 0, 0};
        mh = '{0, 0, 0, 0, 0};
        m3 = '{0, 0, 0, 0, 0};
        reset = 1'b1;
        req4 = '0; w4 = '0; reqh = '0; wh = '0; req3 = '0; w3 = '0;

        // Reset state
        cycle(1, 4'b0, 4'b0, 4'b0, 4'b0, 3'b0, 3'b0);
        cycle(1, 4'b0, 4'b0, 4'b0, 4'b0, 3'b0, 3'b0);
        check("rst_state", 64'({grant4, s4, v4, f4}), 64'(0));

        // Reset mid-grant on the 4/8 instance
        repeat (3) cycle(0, 4'b0010, 4'b1111, 4'b0, 4'b0, 3'b0, 3'b0);
        check("mid_grant_s", 64'(s4), 64'(1));
        cycle(1, 4'b0010, 4'b1111, 4'b0, 4'b0, 3'b0, 3'b0);
        check("mid_rst_drop", 64'({grant4, s4, v4}), 64'(0));
        cycle(0, 4'b0010, 4'b1111, 4'b0, 4'b0, 3'b0, 3'b0);
        check("mid_rst_regrant", 64'(grant4), 64'(4'b0010));

        // Single request with data
        cycle(0, 4'b0000, 4'b0100, 4'b0, 4'b0, 3'b0, 3'b0);
        cycle(0, 4'b0100, 4'b0100, 4'b0, 4'b0, 3'b0, 3'b0);
        check("single_grant", 64'({grant4, s4, v4, f4}), 64'({4'b0100, 2'd2, 1'b1, 1'b1}));
        repeat (3) cycle(0, 4'b0100, 4'b0100, 4'b0, 4'b0, 3'b0, 3'b0);
        cycle(0, 4'b0000, 4'b0100, 4'b0, 4'b0, 3'b0, 3'b0);
        check("single_release", 64'({grant4, v4, f4, s4}), 64'({4'b0, 1'b0, 1'b0, 2'd2}));

        // No preemption: owner 1 keeps grant while req 0 rises
        repeat (2) cycle(0, 4'b0010, 4'b0011, 4'b0, 4'b0, 3'b0, 3'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'b0011, 4'b0011, 4'b0, 4'b0, 3'b0, 3'b0);
            check("nopreempt_s", 64'(s4), 64'(1));
        end
        cycle(0, 4'b0001, 4'b0011, 4'b0, 4'b0, 3'b0, 3'b0);
        check("handover_s", 64'({grant4, s4}), 64'({4'b0001, 2'd0}));

        // Round-robin fairness on the hold-2 instance
        cycle(1, 4'b0, 4'b0, 4'b0, 4'b0, 3'b0, 3'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 4'b0, 4'b0, 4'b1111, 4'b1010, 3'b0, 3'b0);
            check("fair_s", 64'({vh, sh}), 64'({1'b1, 2'((i / 2) % 4)}));
        end

        // Sole requester timeout on the 3-input hold-3 instance
        cycle(1, 4'b0, 4'b0, 4'b0, 4'b0, 3'b0, 3'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 4'b0, 4'b0, 4'b0, 4'b0, 3'b100, 3'b100);
            check("sole_hold", 64'({grant3, v3, f3}), 64'({3'b100, 1'b1, 1'b1}));
        end

        // Wrap: owner 1 releases to idle (ptr=2), then 3'b011 picks 0
        repeat (2) cycle(0, 4'b0, 4'b0, 4'b0, 4'b0, 3'b010, 3'b001);
        check("wrap_owner1", 64'(s3), 64'(1));
        cycle(0, 4'b0, 4'b0, 4'b0, 4'b0, 3'b000, 3'b001);
        cycle(0, 4'b0, 4'b0, 4'b0, 4'b0, 3'b011, 3'b001);
        check("wrap_s3", 64'({grant3, s3, f3}), 64'({3'b001, 2'd0, 1'b1}));

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 3'($urandom));
            check("s3_range", 64'(s3 != 2'd3), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one generic 1-bit mux among `inputs` requesters.
- Accepts per-requester request lines and produces a one-hot grant, the binary mux select, and the muxed data bit.
- Each grant is held until the owner drops its request, or for at most `max_hold` cycles.
- Sits in front of the mux and drives its select, so one requester at a time owns the shared bit path.

Parameters:
- inputs, 4, number of requesters / mux data inputs; legal range 2..64, non-power-of-2 allowed.
- max_hold, 8, maximum consecutive cycles one owner keeps the grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_in  input  inputs  request per requester; level-sensitive, held while service is wanted.
- w_in  input  inputs  data bit per requester (mux data inputs).
- grant_out  output  inputs  one-hot grant, registered; all-zero when idle.
- s_out  output  $clog2(inputs)  binary index of current owner, registered.
- valid_out  output  1  high while a grant is active, registered.
- f_out  output  1  w_in[s_out] when valid_out=1, else 0; combinational from registered select.

Behaviour:
- Reset (reset=1 at a clk edge):
  - grant_out=0, s_out=0, valid_out=0, f_out=0.
  - Internal state=IDLE, priority pointer ptr=0, hold_cnt=0.
  - Reset overrides everything, including a grant in progress; the grant drops on the next edge.
- Arbitration function pick(mask):
  - Returns the first set bit of mask scanning ptr, ptr+1, …, inputs-1, 0, …, ptr-1.
  - Index arithmetic wraps modulo `inputs`, not modulo a power of 2.
- State IDLE:
  - If req_in==0: stay in IDLE, outputs stay zero.
  - Else, next edge: owner=pick(req_in); grant_out=onehot(owner); s_out=owner; valid_out=1; hold_cnt=1; state=GRANT.
  - Latency from req_in sampled high to grant_out high is 1 cycle.
- State GRANT, evaluated each edge, in this priority order:
  - req_in[owner]=0 → release.
  - hold_cnt==max_hold → release (timeout).
  - Otherwise → keep the grant, hold_cnt+=1, outputs unchanged.
- Release:
  - ptr=(owner+1) mod inputs.
  - other=req_in with bit owner cleared.
  - If other≠0: re-arbitrate in the same edge using the updated ptr; new owner granted with no idle cycle; hold_cnt=1.
  - Else if timeout and req_in[owner]=1 (sole requester): owner re-granted; hold_cnt=1; grant stays continuously high.
  - Else: grant_out=0, valid_out=0, state=IDLE; s_out keeps its last value.
- Requests on non-owner lines never preempt the owner before release.
- A requester that drops and reasserts req_in while not owner has no effect until the next arbitration.
- hold_cnt width is $clog2(max_hold+1); it never exceeds max_hold.
- grant_out is always one-hot or zero. s_out always matches the grant index when valid_out=1.
- f_out is 0 whenever valid_out=0. No X is ever driven on any output.

Test Plan:
- Reset mid-grant: req_in=4'b0010 for 3 cycles, assert reset 1 cycle → next edge grant_out=0, valid_out=0, s_out=0; with req still 4'b0010, grant returns 1 cycle after reset deasserts.
- Single request: req_in=4'b0100 from cycle 0, w_in=4'b0100 → cycle 1 grant_out=4'b0100, s_out=2, valid_out=1, f_out=1; drop req at cycle 4 → cycle 5 grant_out=0, valid_out=0.
- Round-robin fairness: req_in=4'b1111 held, max_hold=2:
  - Grants are 0,0,1,1,2,2,3,3,0… with no idle cycles.
  - grant_out one-hot every cycle.
- Timeout with sole requester: max_hold=3, req_in=4'b1000 held for 10 cycles → grant_out=4'b1000 continuously, hold_cnt sequence 1,2,3,1,2,3…
- Wrap and non-power-of-2: inputs=3, ptr=2 after owner 1 released, req_in=3'b011 → next grant index 0, not 1; s_out width 2, never equals 3.
- No preemption: owner 1 holding, req_in[0] rises at cycle k → grant stays at 1 until req_in[1] falls; then grant moves to 0 on the same edge (ptr=2 scan wraps to 0).
